// File: rtl/ram2e_cmd_seq.sv
// RAM2E command-sequence recognizer: tracks the 8-step unlock
// sequence on bank-register writes and raises command set levels.
module ram2e_cmd_seq #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  CMD_RWMASK = 8'h2A,
  parameter logic [7:0]  CMD_LED    = 8'hE1
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic [3:0] S,
  input  logic       RWSel,
  input  logic [7:0] D,
  output logic [2:0] CS,
  output logic [7:0] CmdByte,
  output logic       CmdRWMaskSet,
  output logic       CmdLEDSet
);

  typedef enum logic [2:0] {
    ST0, ST1, ST2, ST3, ST4, ST5, ST6, ST7
  } step_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  step_t      cs_q;
  logic [7:0] to_q;
  logic [1:0] rst_sync;
  logic       rst_n;
  logic       ph_init;
  logic       ph_wr;
  logic       w;
  logic [7:0] exp_byte;

  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    ph_init  = (S == 4'h0);
    ph_wr    = (S == 4'hC);
    w        = ph_wr && RWSel;
    exp_byte = 8'h00;
    case (cs_q)
      ST0:     exp_byte = 8'hFF;
      ST1:     exp_byte = 8'h00;
      ST2:     exp_byte = 8'h55;
      ST3:     exp_byte = 8'hAA;
      ST4:     exp_byte = 8'hC1;
      ST5:     exp_byte = 8'hAD;
      default: exp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge C14M or negedge rst_n) begin
    if (!rst_n) begin
      cs_q         <= ST0;
      to_q         <= 8'h00;
      CmdByte      <= 8'h00;
      CmdRWMaskSet <= 1'b0;
      CmdLEDSet    <= 1'b0;
    end else if (ph_init) begin
      cs_q         <= ST0;
      to_q         <= 8'h00;
      CmdRWMaskSet <= 1'b0;
      CmdLEDSet    <= 1'b0;
    end else if (w) begin
      to_q <= 8'h00;
      case (cs_q)
        ST6: begin
          cs_q         <= ST7;
          CmdByte      <= D;
          CmdRWMaskSet <= (D == CMD_RWMASK);
          CmdLEDSet    <= (D == CMD_LED);
        end
        ST7: begin
          cs_q         <= ST0;
          CmdRWMaskSet <= 1'b0;
          CmdLEDSet    <= 1'b0;
        end
        default: begin
          // A stray FF counts as the first unlock byte
          if (D == exp_byte)   cs_q <= step_t'(cs_q + 3'd1);
          else if (D == 8'hFF) cs_q <= ST1;
          else                 cs_q <= ST0;
        end
      endcase
    end else if (cs_q == ST0) begin
      to_q <= 8'h00;
    end else if (ph_wr) begin
      if (to_q == TO_LAST) begin
        cs_q         <= ST0;
        to_q         <= 8'h00;
        CmdRWMaskSet <= 1'b0;
        CmdLEDSet    <= 1'b0;
      end else begin
        to_q <= to_q + 8'd1;
      end
    end
  end

  assign CS = cs_q;

endmodule
